// File: rtl/iter_div_if.sv
// iter_div_if: request/result bundle between the execute stage (master) and iter_div (slave).
interface iter_div_if;
  logic        is_flush;
  logic        is_stall;
  logic        en;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  modport master (output is_flush, is_stall, en, is_signed, dividend, divisor,
                  input quotient, remainder, done);
  modport slave (input is_flush, is_stall, en, is_signed, dividend, divisor,
                 output quotient, remainder, done);
endinterface

// File: rtl/iter_div.sv
// iter_div: 32-bit radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and |dividend| < |divisor| at the start edge.
module iter_div (
  input  logic       clk,
  input  logic       rst_n,
  iter_div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] a, r, d, q_r, r_r, am, bm, a_nx, r_nx;
  logic        qs, rs, ge, early, start;
  logic [4:0]  cnt;
  logic [32:0] sh;
  assign am = (bus.is_signed & bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign bm = (bus.is_signed & bus.divisor[31]) ? -bus.divisor : bus.divisor;
`ifdef DIV_EARLY_OUT_EN
  assign early = (bus.divisor == '0) || (am < bm);
`else
  assign early = 1'b0;
`endif
  assign start = state == IDLE && bus.en;
  assign sh = {r, a[31]};
  assign ge = sh >= {1'b0, d};
  assign a_nx = {a[30:0], ge};
  assign r_nx = ge ? 32'(sh - {1'b0, d}) : sh[31:0];
  assign bus.quotient = q_r;
  assign bus.remainder = r_r;
  assign bus.done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (bus.is_flush) state_nx = IDLE;
    else if (start) state_nx = early ? DONE : CALC;
    else if (state == CALC && cnt == 5'd31) state_nx = DONE;
    else if (state == DONE && !bus.is_stall) state_nx = IDLE;
  end
  // Quotient sign is suppressed for a zero divisor so the all-ones result survives fixup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      r <= '0;
      d <= '0;
      qs <= 1'b0;
      rs <= 1'b0;
      cnt <= '0;
      q_r <= '0;
      r_r <= '0;
    end else if (!bus.is_flush) begin
      if (start) begin
        a <= am;
        d <= bm;
        r <= '0;
        cnt <= '0;
        qs <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]) & |bus.divisor;
        rs <= bus.is_signed & bus.dividend[31];
        if (early) begin
          q_r <= (bus.divisor == '0) ? '1 : '0;
          r_r <= bus.dividend;
        end
      end else if (state == CALC) begin
        a <= a_nx;
        r <= r_nx;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          q_r <= qs ? -a_nx : a_nx;
          r_r <= rs ? -r_nx : r_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: randomized scoreboard bench for iter_div against a plain-arithmetic model.
module tb_iter_div;
  logic clk, rst_n;
  iter_div_if bus();
  iter_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur;
  logic done_q = 1'b0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask
  function automatic logic [31:0] mag(bit s, logic [31:0] v);
    return (s && $signed(v) < 0) ? 32'(-$signed(v)) : v;
  endfunction
  function automatic logic [63:0] model(bit s, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction
  // Monitor: pops an expectation on each rising done, then holds it while done stays high.
  always @(negedge clk) begin
    if (bus.done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no result pending");
        cur = 'x;
      end else begin
        cur = exp_q.pop_front();
        check("quotient", bus.quotient, cur[63:32]);
        check("remainder", bus.remainder, cur[31:0]);
      end
    end else if (bus.done && done_q) begin
      check("hold_quotient", bus.quotient, cur[63:32]);
      check("hold_remainder", bus.remainder, cur[31:0]);
    end
    done_q = bus.done;
  end
  task automatic op(bit s, logic [31:0] a, logic [31:0] b, int stall);
    int lat, w, lat_req;
    bit got;
    lat_req = 33;
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || mag(s, a) < mag(s, b)) lat_req = 1;
`endif
    bus.en = 1'b1;
    bus.is_signed = s;
    bus.dividend = a;
    bus.divisor = b;
    exp_q.push_back(model(s, a, b));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      got = bus.done;
      bus.dividend = $urandom;
      bus.divisor = $urandom;
      bus.is_signed = 1'($urandom);
    end
    bus.en = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done at %0d", lat, lat_req);
      void'(exp_q.pop_back());
      return;
    end
    check("latency", 32'(lat), 32'(lat_req));
    bus.is_stall = stall != 0;
    w = 1;
    repeat (stall) begin
      @(negedge clk);
      if (bus.done) w++;
    end
    bus.is_stall = 1'b0;
    check("done_width", 32'(w), 32'(stall + 1));
    @(negedge clk);
    check("done_low_after", 32'(bus.done), 32'd0);
  endtask
  initial begin
    int seen;
    rst_n = 1'b0;
    bus.is_flush = 1'b0;
    bus.is_stall = 1'b0;
    bus.en = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_quotient", bus.quotient, 32'd0);
    check("reset_remainder", bus.remainder, 32'd0);
    op(1'b0, 32'd100, 32'd7, 0);
    op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    op(1'b0, 32'h1234, 32'd0, 0);
    op(1'b1, 32'hFFFF_FF00, 32'd0, 1);
    op(1'b1, 32'd5, 32'hFFFF_FFFE, 0);
    op(1'b0, 32'hDEAD_BEEF, 32'h0001_0003, 5);
    op(1'b1, 32'h8000_0000, 32'd3, 0);
    // Flush mid-iteration: no result may appear for the aborted op.
    bus.en = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd3;
    repeat (10) @(negedge clk);
    bus.is_flush = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    bus.is_flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    // Asynchronous reset mid-CALC.
    bus.en = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend = 32'h7654_3210;
    bus.divisor = 32'd9;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0;
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(1'b0, 32'd100, 32'd7, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom & 32'hFF;
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      op(1'($urandom), a, b, int'($urandom_range(0, 3)));
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iter_div.md
# iter_div

Iterative 32-bit radix-2 integer divider serving the execute stage's divide path. It accepts an operand pair when the stage raises `en` and computes signed or unsigned quotient and remainder at one bit per cycle. It raises `done` and holds the result until the stage consumes it, and aborts on pipeline flush. Execute stalls itself while `is_div && !done` and drives `en = is_div && !done`.

## Interface
- No parameters (fixed 32-bit datapath).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `is_flush`  in  1  execute stage flushed or empty; aborts any operation.
- `is_stall`  in  1  downstream not ready (`~next_rdy_in`); result must be held.
- `en`  in  1  start request; held high by the initiator until `done`.
- `is_signed`  in  1  1 = DIV.W/MOD.W, 0 = DIV.WU/MOD.WU; sampled with `en`.
- `dividend`  in  32  rj operand, forwarded; sampled at start.
- `divisor`  in  32  rkd operand, forwarded; sampled at start.
- `quotient`  out  32  registered quotient, valid while `done`.
- `remainder`  out  32  registered remainder, valid while `done`.
- `done`  out  1  result valid; decoded from state == DONE.

## Operation
- FSM states: IDLE, CALC, DONE. Reset: IDLE, `quotient` = 0, `remainder` = 0, `done` = 0, counter = 0.
- IDLE → CALC when `en & ~is_flush`:
  - latch magnitudes |dividend| and |divisor|. Absolute value is taken only when `is_signed`; otherwise the raw value.
  - latch the quotient sign (`is_signed & (dividend[31] ^ divisor[31])`) and the remainder sign (`is_signed & dividend[31]`).
  - clear the partial remainder and set counter = 0.
- CALC, each cycle:
  - shift {partial remainder, dividend} left by 1.
  - trial-subtract the divisor magnitude using a 33-bit subtract. If non-negative, keep the difference and shift in quotient bit 1; else 0.
  - counter++.
- CALC → DONE after the 32nd iteration (counter == 31 at the edge). Sign fixup is applied on this edge into the `quotient`/`remainder` registers:
  - negate the quotient if its sign flag is set;
  - negate the remainder if its sign flag is set.
- DONE → IDLE when `~is_stall` (result consumed that cycle). Stays in DONE while `is_stall`, with outputs constant.
- `is_flush` in any state: next state IDLE, `done` low next cycle. Result registers need not be cleared. Flush takes priority over all transitions, including IDLE start.
- `en` in CALC/DONE is ignored; `is_stall` in CALC does not pause iteration.
- Divisor == 0 (any signedness): `quotient` = 32'hFFFF_FFFF, `remainder` = raw dividend. Same latency unless early-out is enabled.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: `quotient` = 0x8000_0000, `remainder` = 0. This is the natural wrap; no trap.
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Start at edge E0 (IDLE, `en`=1, `is_flush`=0). CALC runs edges E1..E32. `done` is high in the cycle after E32, i.e. 33 cycles after `en` is first seen.
- Minimum `done` width is 1 cycle; it is extended by every `is_stall` cycle.
- Back-to-back: after DONE exits on edge Ex, IDLE can start at Ex+1. At least one `done`-low cycle separates results, so the initiator's `en = is_div && !done` is clean.
- Reset asserted mid-CALC/DONE: immediate IDLE, outputs zero.

## Configuration
- `DIV_EARLY_OUT_EN` defined: at the IDLE start edge, an early out applies if divisor == 0, or if |dividend| < |divisor| in unsigned magnitude. The FSM goes directly IDLE → DONE with final values: quotient 0 (or all-ones for divide-by-zero), remainder = raw dividend. `done` is high 1 cycle after `en`.
- Not defined: every operation takes the full 32-iteration path; results are identical.

## Test plan
- Unsigned 100 / 7, no stall → `done` at cycle 33, `quotient` = 14, `remainder` = 2; `done` low the next cycle.
- Signed −7 / 2 → `quotient` = 0xFFFF_FFFD (−3), `remainder` = 0xFFFF_FFFF (−1). Signed 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, 0.
- Divide-by-zero 0x1234 / 0 → `quotient` = 0xFFFF_FFFF, `remainder` = 0x1234. Latency is 33 cycles without `DIV_EARLY_OUT_EN`, 1 with it.
- `is_stall` high for 5 cycles after `done` → `done` and outputs stable for 6 cycles. A new `en` in the cycle after release starts the next op correctly.
- `is_flush` pulsed at CALC iteration 10 → `done` never asserts for that op. A fresh unsigned 0xFFFF_FFFF / 1 afterwards → `quotient` = 0xFFFF_FFFF, `remainder` = 0.
- `rst_n` dropped mid-CALC → outputs 0 and `done` = 0 immediately. After release, the FSM accepts `en` normally.
